// File: rtl/dma_job_scheduler.sv
// rtl/dma_job_scheduler.sv - descriptor FIFO feeding a single-job read/write DMA launcher
// One job in flight: pop, pulse both DMA starts, wait for both dones (or watchdog), report.
module dma_job_scheduler #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_src,
   input  logic [31:0] cmd_dst,
   input  logic [31:0] cmd_len,
   input  logic [3:0]  cmd_id,
   output logic        rd_start,
   output logic [31:0] rd_base,
   output logic [31:0] rd_length,
   input  logic        rd_done,
   output logic        wr_start,
   output logic [31:0] wr_base,
   output logic [31:0] wr_length,
   input  logic        wr_done,
   output logic        cpl_valid,
   input  logic        cpl_ready,
   output logic [3:0]  cpl_id,
   output logic        cpl_err,
   output logic        busy,
   output logic [15:0] jobs_done
);
   localparam int          AW      = $clog2(FIFO_DEPTH);
   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
   localparam bit          WDOG_EN = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_CPL} state_t;

   state_t      state;
   logic [31:0] q_src [FIFO_DEPTH];
   logic [31:0] q_dst [FIFO_DEPTH];
   logic [31:0] q_len [FIFO_DEPTH];
   logic [3:0]  q_id  [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [31:0] job_src, job_dst, job_len, timer;
   logic [3:0]  job_id;
   logic        rd_seen, wr_seen;
   logic        full, empty, push, pop, rd_hit, wr_hit;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state == S_IDLE) && !empty;
   assign busy      = (state != S_IDLE) || !empty;
   assign rd_hit    = rd_seen || rd_done;
   assign wr_hit    = wr_seen || wr_done;

   assign rd_base   = job_src;
   assign rd_length = job_len;
   assign wr_base   = job_dst;
   assign wr_length = job_len;

   // Descriptor storage carries no reset; emptiness lives in the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_src[wr_ptr] <= cmd_src;
         q_dst[wr_ptr] <= cmd_dst;
         q_len[wr_ptr] <= cmd_len;
         q_id[wr_ptr]  <= cmd_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (!push && pop) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         job_src   <= '0;
         job_dst   <= '0;
         job_len   <= '0;
         job_id    <= '0;
         timer     <= '0;
         rd_seen   <= 1'b0;
         wr_seen   <= 1'b0;
         rd_start  <= 1'b0;
         wr_start  <= 1'b0;
         cpl_valid <= 1'b0;
         cpl_id    <= '0;
         cpl_err   <= 1'b0;
         jobs_done <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  job_src <= q_src[rd_ptr];
                  job_dst <= q_dst[rd_ptr];
                  job_len <= q_len[rd_ptr];
                  job_id  <= q_id[rd_ptr];
                  if (q_len[rd_ptr] == '0) begin
                     state     <= S_CPL;
                     cpl_valid <= 1'b1;
                     cpl_id    <= q_id[rd_ptr];
                     cpl_err   <= 1'b1;
                  end else begin
                     state    <= S_LAUNCH;
                     rd_start <= 1'b1;
                     wr_start <= 1'b1;
                  end
               end
            end
            S_LAUNCH: begin
               rd_start <= 1'b0;
               wr_start <= 1'b0;
               timer    <= '0;
               rd_seen  <= 1'b0;
               wr_seen  <= 1'b0;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               // Completion is tested first so it beats a watchdog expiry in the same cycle.
               if (rd_hit && wr_hit) begin
                  state     <= S_CPL;
                  cpl_valid <= 1'b1;
                  cpl_id    <= job_id;
                  cpl_err   <= 1'b0;
               end else if (WDOG_EN && timer == TO_LAST) begin
                  state     <= S_CPL;
                  cpl_valid <= 1'b1;
                  cpl_id    <= job_id;
                  cpl_err   <= 1'b1;
               end else begin
                  timer   <= timer + 32'd1;
                  rd_seen <= rd_hit;
                  wr_seen <= wr_hit;
               end
            end
            S_CPL: begin
               if (cpl_ready) begin
                  state     <= S_IDLE;
                  cpl_valid <= 1'b0;
                  rd_seen   <= 1'b0;
                  wr_seen   <= 1'b0;
                  jobs_done <= jobs_done + 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dma_job_scheduler.sv
// tb/tb_dma_job_scheduler.sv - scoreboard bench for dma_job_scheduler
// Expected completions are queued at push time; monitors compare as the DUT presents them.
module tb_dma_job_scheduler;
   localparam int T = 24;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [31:0] cmd_src = '0, cmd_dst = '0, cmd_len = '0;
   logic [3:0]  cmd_id = '0;
   logic        rd_start, wr_start, rd_done = 1'b0, wr_done = 1'b0;
   logic [31:0] rd_base, rd_length, wr_base, wr_length;
   logic        cpl_valid, cpl_ready = 1'b0, cpl_err, busy;
   logic [3:0]  cpl_id;
   logic [15:0] jobs_done;

   always #5 clk = ~clk;

   dma_job_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
      .cmd_len(cmd_len), .cmd_id(cmd_id),
      .rd_start(rd_start), .rd_base(rd_base), .rd_length(rd_length), .rd_done(rd_done),
      .wr_start(wr_start), .wr_base(wr_base), .wr_length(wr_length), .wr_done(wr_done),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_id(cpl_id), .cpl_err(cpl_err),
      .busy(busy), .jobs_done(jobs_done)
   );

   typedef struct {logic [3:0] id; logic err;} cpl_t;
   typedef struct {logic [31:0] src; logic [31:0] dst; logic [31:0] len;} job_t;
   typedef struct {int drd; int dwr;} dly_t;

   cpl_t exp_q[$];
   job_t launch_q[$];
   dly_t dly_q[$];
   int   n_cmp = 0, n_bad = 0, n_done = 0;
   bit   hold = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
      end
   endtask

   // Done delays are counted in WAIT cycles from 0; a delay of T lands in CPL and must be ignored.
   task automatic push_job(input logic [31:0] src, input logic [31:0] dst, input logic [31:0] len,
                           input logic [3:0] id, input int drd, input int dwr);
      int k = 0;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_src = src; cmd_dst = dst; cmd_len = len; cmd_id = id;
      @(negedge clk);
      while (!cmd_ready && k < 600) begin @(negedge clk); k++; end
      if (k >= 600) chk("push_wait", 32'(cmd_ready), 32'd1);
      else begin
         exp_q.push_back(cpl_t'{id, (len == 0) || (drd >= T) || (dwr >= T)});
         if (len != 0) begin
            launch_q.push_back(job_t'{src, dst, len});
            dly_q.push_back(dly_t'{drd, dwr});
         end
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int k = 0;
      while ((exp_q.size() != 0 || busy) && k < 3000) begin @(negedge clk); k++; end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_reset();
      chk("rst_rd_start", 32'(rd_start), 0);   chk("rst_wr_start", 32'(wr_start), 0);
      chk("rst_cpl_valid", 32'(cpl_valid), 0); chk("rst_cpl_id", 32'(cpl_id), 0);
      chk("rst_cpl_err", 32'(cpl_err), 0);     chk("rst_jobs_done", 32'(jobs_done), 0);
      chk("rst_rd_base", rd_base, 0);          chk("rst_rd_length", rd_length, 0);
      chk("rst_wr_base", wr_base, 0);          chk("rst_wr_length", wr_length, 0);
      chk("rst_cmd_ready", 32'(cmd_ready), 1); chk("rst_busy", 32'(busy), 0);
   endtask

   initial forever begin
      @(posedge clk); #1;
      cpl_ready = !hold && ($urandom_range(0, 3) != 0);
   end

   // DMA responder: after each start, pulse the dones at the delays queued for that job.
   initial forever begin
      @(negedge clk);
      if (rst_n && rd_start) begin
         dly_t d;
         int   last;
         d = '{0, 0};
         if (dly_q.size() != 0) d = dly_q.pop_front();
         last = (d.drd > d.dwr) ? d.drd : d.dwr;
         @(posedge clk); #1;
         for (int c = 0; c <= last; c++) begin
            rd_done = (c == d.drd);
            wr_done = (c == d.dwr);
            @(posedge clk); #1;
         end
         rd_done = 1'b0; wr_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n && (rd_start || wr_start)) begin
         chk("start_pair", {30'b0, rd_start, wr_start}, 32'd3);
         if (launch_q.size() == 0) chk("start_expected", 32'(launch_q.size()), 32'd1);
         else begin
            job_t j;
            j = launch_q.pop_front();
            chk("rd_base", rd_base, j.src);   chk("rd_length", rd_length, j.len);
            chk("wr_base", wr_base, j.dst);   chk("wr_length", wr_length, j.len);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cpl_valid) begin
         if (exp_q.size() == 0) chk("cpl_expected", 32'(exp_q.size()), 32'd1);
         else begin
            chk("cpl_id", 32'(cpl_id), 32'(exp_q[0].id));
            chk("cpl_err", 32'(cpl_err), 32'(exp_q[0].err));
         end
         chk("no_start_in_cpl", 32'(rd_start | wr_start), 32'd0);
         if (cpl_ready) begin
            chk("jobs_done", 32'(jobs_done), 32'(n_done[15:0]));
            n_done++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int k;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset();
      @(posedge clk); #1 rst_n = 1'b1;

      push_job(32'h100, 32'h800, 32'd16, 4'd3, 1, 21);
      @(negedge clk); chk("lat_early", 32'(rd_start), 0);
      @(negedge clk); chk("lat_start", 32'(rd_start), 1);
      drain();
      chk("jobs_done_single", 32'(jobs_done), 32'd1);

      push_job(32'h1000, 32'h2000, 32'd64, 4'd5, 5, 2);
      push_job(32'h1100, 32'h2100, 32'd64, 4'd6, 2, 5);
      push_job(32'h1200, 32'h2200, 32'd64, 4'd7, 3, 3);
      drain();

      hold = 1'b1;
      push_job(32'h3000, 32'h4000, 32'd128, 4'd8, 10, 10);
      repeat (4) @(posedge clk);
      for (int i = 0; i < 4; i++) push_job(32'h3100 + i, 32'h4100 + i, 32'd8, 4'(9 + i), 1, 2);
      @(negedge clk); chk("cmd_ready_full", 32'(cmd_ready), 0);
      fork
         push_job(32'h3200, 32'h4200, 32'd8, 4'd13, 2, 1);
         begin
            k = 0;
            while (!cpl_valid && k < 100) begin @(negedge clk); k++; end
            repeat (10) begin @(negedge clk); chk("cmd_ready_stall", 32'(cmd_ready), 0); end
            hold = 1'b0;
         end
      join
      drain();

      push_job(32'h5000, 32'h6000, 32'd0, 4'd1, 0, 0);
      drain();
      push_job(32'h5100, 32'h6100, 32'd64, 4'd2, T, T);
      k = 0;
      do begin @(negedge clk); k++; end while (!rd_start && k < 20);
      k = 0;
      while (!cpl_valid && k < 100) begin @(negedge clk); k++; end
      chk("timeout_latency", 32'(k), 32'(T + 1));
      push_job(32'h5200, 32'h6200, 32'd32, 4'd4, 3, 4);
      drain();

      for (int i = 0; i < 40; i++) begin
         logic [31:0] len;
         len = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
         push_job($urandom, $urandom, len, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, T - 1),
                  ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, T - 1));
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      drain();

      push_job(32'h7000, 32'h8000, 32'd256, 4'd10, 20, 20);
      push_job(32'h7100, 32'h8100, 32'd16, 4'd11, 1, 1);
      push_job(32'h7200, 32'h8200, 32'd16, 4'd12, 1, 1);
      @(posedge clk); #1 rst_n = 1'b0;
      exp_q.delete(); launch_q.delete(); dly_q.delete(); n_done = 0;
      @(negedge clk);
      check_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (40) @(posedge clk);
      push_job(32'h9000, 32'hA000, 32'd48, 4'd9, 2, 3);
      drain();
      chk("jobs_done_after_reset", 32'(jobs_done), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
